// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory arbiter: FSM state codes and
// the owner tag recording which requester holds the memory port.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: inst and data sides share one memory port, one
// transaction in flight. Define MEM_ARB_FAIRNESS_EN to hand inst the grant after data.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic        clka,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_data_ok,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        i_stall,
    output logic        d_stall,
    output logic        longest_stall
);

    logic [1:0]  state;
    logic [1:0]  state_next;
    owner_t      owner;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_wr;
    logic [3:0]  lat_wstrb;
    logic        any_req;
    logic        grant_data;
    logic        resp_fire;

`ifdef MEM_ARB_FAIRNESS_EN
    owner_t last_owner;

    // After a data transaction, a waiting inst request goes ahead of data.
    always_comb begin
        grant_data = data_req & ~(inst_req & (last_owner == OWNER_DATA));
    end

    always_ff @(posedge clka or negedge resetn) begin
        if (!resetn) begin
            last_owner <= OWNER_INST;
        end else if (state == ST_DONE) begin
            last_owner <= owner;
        end
    end
`else
    always_comb begin
        grant_data = data_req;
    end
`endif

    assign any_req = inst_req | data_req;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (any_req) state_next = ST_ADDR;
            ST_ADDR: if (mem_addr_ok) state_next = mem_data_ok ? ST_DONE : ST_WAIT;
            ST_WAIT: if (mem_data_ok) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Memory response accepted this cycle; data_ok follows in the DONE cycle.
    assign resp_fire = (state_next == ST_DONE) && (state != ST_DONE);

    always_ff @(posedge clka or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request fields are captured only at grant so later requester changes are ignored.
    always_ff @(posedge clka or negedge resetn) begin
        if (!resetn) begin
            owner     <= OWNER_INST;
            lat_addr  <= 32'h0;
            lat_wdata <= 32'h0;
            lat_wr    <= 1'b0;
            lat_wstrb <= 4'h0;
        end else if ((state == ST_IDLE) && any_req) begin
            if (grant_data) begin
                owner     <= OWNER_DATA;
                lat_addr  <= data_addr;
                lat_wdata <= data_wdata;
                lat_wr    <= data_wr;
                lat_wstrb <= data_wr ? data_wstrb : 4'h0;
            end else begin
                owner     <= OWNER_INST;
                lat_addr  <= inst_addr;
                lat_wdata <= 32'h0;
                lat_wr    <= 1'b0;
                lat_wstrb <= 4'h0;
            end
        end
    end

    always_ff @(posedge clka or negedge resetn) begin
        if (!resetn) begin
            inst_rdata   <= 32'h0;
            data_rdata   <= 32'h0;
            inst_data_ok <= 1'b0;
            data_data_ok <= 1'b0;
        end else begin
            inst_data_ok <= resp_fire && (owner == OWNER_INST);
            data_data_ok <= resp_fire && (owner == OWNER_DATA);
            if (resp_fire && !lat_wr) begin
                if (owner == OWNER_INST) begin
                    inst_rdata <= mem_rdata;
                end else begin
                    data_rdata <= mem_rdata;
                end
            end
        end
    end

    assign mem_req   = (state == ST_ADDR);
    assign mem_wr    = (state == ST_ADDR) & lat_wr;
    assign mem_wstrb = (state == ST_ADDR) ? lat_wstrb : 4'h0;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

    assign i_stall       = inst_req & ~inst_data_ok;
    assign d_stall       = data_req & ~data_data_ok;
    assign longest_stall = i_stall | d_stall;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table plus hand-written
// sequences for slow memory, reset mid-transaction and grant ordering.
module tb_mem_arbiter;

    logic        clka = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_data_ok;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;
    logic        i_stall;
    logic        d_stall;
    logic        longest_stall;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [3:0]  ds;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        aok;
        logic        dok;
        logic [31:0] rd;
        logic        e_mreq;
        logic        e_mwr;
        logic [3:0]  e_mstrb;
        logic [31:0] e_maddr;
        logic        e_iok;
        logic        e_dok;
        logic        e_istall;
        logic        e_dstall;
        logic [31:0] e_ird;
        logic [31:0] e_drd;
    } vec_t;

    vec_t vecs[$];

    always #5 clka = ~clka;

    mem_arbiter dut (
        .clka          (clka),
        .resetn        (resetn),
        .inst_req      (inst_req),
        .inst_addr     (inst_addr),
        .inst_rdata    (inst_rdata),
        .inst_data_ok  (inst_data_ok),
        .data_req      (data_req),
        .data_wr       (data_wr),
        .data_wstrb    (data_wstrb),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_rdata    (data_rdata),
        .data_data_ok  (data_data_ok),
        .mem_req       (mem_req),
        .mem_wr        (mem_wr),
        .mem_wstrb     (mem_wstrb),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_addr_ok   (mem_addr_ok),
        .mem_data_ok   (mem_data_ok),
        .mem_rdata     (mem_rdata),
        .i_stall       (i_stall),
        .d_stall       (d_stall),
        .longest_stall (longest_stall)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        inst_req    = 1'b0;
        inst_addr   = 32'h0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_wstrb  = 4'h0;
        data_addr   = 32'h0;
        data_wdata  = 32'h0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;
    endtask

    task automatic apply_stimulus(input vec_t v);
        inst_req    = v.ir;
        inst_addr   = v.ia;
        data_req    = v.dr;
        data_wr     = v.dw;
        data_wstrb  = v.ds;
        data_addr   = v.da;
        data_wdata  = v.dwd;
        mem_addr_ok = v.aok;
        mem_data_ok = v.dok;
        mem_rdata   = v.rd;
    endtask

    task automatic check_vector(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        check_output({tag, "_mem_req"}, 32'(mem_req), 32'(v.e_mreq));
        check_output({tag, "_mem_wr"}, 32'(mem_wr), 32'(v.e_mwr));
        check_output({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'(v.e_mstrb));
        if (v.e_mreq) check_output({tag, "_mem_addr"}, mem_addr, v.e_maddr);
        if (v.e_mwr) check_output({tag, "_mem_wdata"}, mem_wdata, v.dwd);
        check_output({tag, "_inst_data_ok"}, 32'(inst_data_ok), 32'(v.e_iok));
        check_output({tag, "_data_data_ok"}, 32'(data_data_ok), 32'(v.e_dok));
        check_output({tag, "_i_stall"}, 32'(i_stall), 32'(v.e_istall));
        check_output({tag, "_d_stall"}, 32'(d_stall), 32'(v.e_dstall));
        check_output({tag, "_longest_stall"}, 32'(longest_stall), 32'(v.e_istall | v.e_dstall));
        check_output({tag, "_inst_rdata"}, inst_rdata, v.e_ird);
        check_output({tag, "_data_rdata"}, data_rdata, v.e_drd);
    endtask

    initial begin
        int          pulses;
        int          grants;
        logic [3:0]  order;
        logic [3:0]  exp_order;

        // Inst fetch with same-cycle addr_ok/data_ok.
        vecs.push_back('{1'b1, 32'hBFC00000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                         1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 32'hBFC00000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h24080001,
                         1'b1, 1'b0, 4'h0, 32'hBFC00000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 32'hBFC00000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                         1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h24080001, 32'h0});
        vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                         1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h24080001, 32'h0});
        // Simultaneous requests: data first, then inst; inst_addr change after grant ignored.
        vecs.push_back('{1'b1, 32'hBFC00004, 1'b1, 1'b0, 4'h0, 32'h80001000, 32'h0, 1'b0, 1'b0, 32'h0,
                         1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h24080001, 32'h0});
        vecs.push_back('{1'b1, 32'hBFC00004, 1'b1, 1'b0, 4'h0, 32'h80001000, 32'h0, 1'b1, 1'b1, 32'h11112222,
                         1'b1, 1'b0, 4'h0, 32'h80001000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h24080001, 32'h0});
        vecs.push_back('{1'b1, 32'hBFC00004, 1'b1, 1'b0, 4'h0, 32'h80001000, 32'h0, 1'b0, 1'b0, 32'h0,
                         1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h24080001, 32'h11112222});
        vecs.push_back('{1'b1, 32'hBFC00004, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                         1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h24080001, 32'h11112222});
        vecs.push_back('{1'b1, 32'h00000000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h33334444,
                         1'b1, 1'b0, 4'h0, 32'hBFC00004, 1'b0, 1'b0, 1'b1, 1'b0, 32'h24080001, 32'h11112222});
        vecs.push_back('{1'b1, 32'h00000000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h66666666,
                         1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h33334444, 32'h11112222});
        vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h55555555,
                         1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h33334444, 32'h11112222});
        // Store with partial strobe; stray rdata in WAIT must not reach data_rdata.
        vecs.push_back('{1'b0, 32'h0, 1'b1, 1'b1, 4'h3, 32'h80002000, 32'h0000ABCD, 1'b0, 1'b0, 32'h0,
                         1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h33334444, 32'h11112222});
        vecs.push_back('{1'b0, 32'h0, 1'b1, 1'b1, 4'h3, 32'h80002000, 32'h0000ABCD, 1'b1, 1'b0, 32'h0,
                         1'b1, 1'b1, 4'h3, 32'h80002000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h33334444, 32'h11112222});
        vecs.push_back('{1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hDEADBEEF,
                         1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h33334444, 32'h11112222});
        vecs.push_back('{1'b0, 32'h0, 1'b1, 1'b1, 4'h3, 32'h80002000, 32'h0000ABCD, 1'b0, 1'b0, 32'h0,
                         1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h33334444, 32'h11112222});
        vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                         1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h33334444, 32'h11112222});

        idle_inputs();
        resetn = 1'b0;
        repeat (2) @(negedge clka);
        #1;
        check_output("rst_mem_req", 32'(mem_req), 32'h0);
        check_output("rst_inst_data_ok", 32'(inst_data_ok), 32'h0);
        check_output("rst_data_data_ok", 32'(data_data_ok), 32'h0);
        check_output("rst_inst_rdata", inst_rdata, 32'h0);
        check_output("rst_data_rdata", data_rdata, 32'h0);
        @(negedge clka);
        resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clka);
            apply_stimulus(vecs[i]);
            #1;
            check_vector(i, vecs[i]);
        end

        // Slow memory: addr_ok after 3 cycles of mem_req, data_ok 2 cycles later.
        @(negedge clka);
        idle_inputs();
        inst_req  = 1'b1;
        inst_addr = 32'h00400000;
        #1;
        check_output("slow_idle_mem_req", 32'(mem_req), 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clka);
            mem_addr_ok = 1'b0;
            #1;
            check_output($sformatf("slow_hold%0d_mem_req", k), 32'(mem_req), 32'h1);
            check_output($sformatf("slow_hold%0d_mem_addr", k), mem_addr, 32'h00400000);
        end
        @(negedge clka);
        mem_addr_ok = 1'b1;
        #1;
        check_output("slow_accept_mem_req", 32'(mem_req), 32'h1);
        @(negedge clka);
        mem_addr_ok = 1'b0;
        #1;
        check_output("slow_wait_mem_req", 32'(mem_req), 32'h0);
        @(negedge clka);
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hCAFEF00D;
        #1;
        check_output("slow_wait_i_stall", 32'(i_stall), 32'h1);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clka);
            mem_data_ok = 1'b0;
            if (pulses > 0) inst_req = 1'b0;
            #1;
            if (inst_data_ok) pulses++;
        end
        check_output("slow_ok_pulses", 32'(pulses), 32'h1);
        check_output("slow_inst_rdata", inst_rdata, 32'hCAFEF00D);

        // Reset asserted during WAIT, then a stale data_ok after release.
        @(negedge clka);
        idle_inputs();
        data_req  = 1'b1;
        data_addr = 32'h80003000;
        @(negedge clka);
        mem_addr_ok = 1'b1;
        #1;
        check_output("rstmid_addr_mem_req", 32'(mem_req), 32'h1);
        @(negedge clka);
        mem_addr_ok = 1'b0;
        #1;
        check_output("rstmid_wait_mem_req", 32'(mem_req), 32'h0);
        resetn = 1'b0;
        #1;
        check_output("rstmid_async_inst_rdata", inst_rdata, 32'h0);
        check_output("rstmid_async_data_rdata", data_rdata, 32'h0);
        @(negedge clka);
        resetn      = 1'b1;
        data_req    = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hBADBADBA;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clka);
            if (k > 0) mem_data_ok = 1'b0;
            #1;
            if (data_data_ok || inst_data_ok || mem_req) pulses++;
        end
        check_output("rstmid_no_activity", 32'(pulses), 32'h0);
        check_output("rstmid_data_rdata", data_rdata, 32'h0);
        @(negedge clka);
        idle_inputs();
        inst_req    = 1'b1;
        inst_addr   = 32'h00500000;
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h12345678;
        #1;
        check_output("rstmid_fresh_idle", 32'(mem_req), 32'h0);
        @(negedge clka);
        #1;
        check_output("rstmid_fresh_mem_req", 32'(mem_req), 32'h1);
        check_output("rstmid_fresh_mem_addr", mem_addr, 32'h00500000);
        @(negedge clka);
        #1;
        check_output("rstmid_fresh_ok", 32'(inst_data_ok), 32'h1);
        check_output("rstmid_fresh_rdata", inst_rdata, 32'h12345678);
        @(negedge clka);
        idle_inputs();

        // Grant order with data_req held for three grants and inst_req always high.
`ifdef MEM_ARB_FAIRNESS_EN
        exp_order = 4'b0101;
`else
        exp_order = 4'b0111;
`endif
        grants = 0;
        order  = 4'b0000;
        for (int c = 0; c < 40 && grants < 4; c++) begin
            @(negedge clka);
            inst_req    = 1'b1;
            inst_addr   = 32'h00600000;
            data_req    = (grants < 3);
            data_addr   = 32'h80006000;
            data_wr     = 1'b0;
            mem_addr_ok = 1'b1;
            mem_data_ok = 1'b1;
            mem_rdata   = 32'h0;
            #1;
            if (mem_req) begin
                order[grants] = (mem_addr == 32'h80006000);
                grants++;
            end
        end
        check_output("order_grant_count", 32'(grants), 32'h4);
        for (int k = 0; k < 4; k++) begin
            check_output($sformatf("order_grant%0d_is_data", k), 32'(order[k]), 32'(exp_order[k]));
        end
        @(negedge clka);
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
